// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction/resolution unit: branch op
// encodings and branch-history counter geometry.
package bpu_pkg;

   localparam logic [2:0] BCU_NONE  = 3'b000;
   localparam logic [2:0] BCU_BEQ   = 3'b001;
   localparam logic [2:0] BCU_BGE   = 3'b010;
   localparam logic [2:0] BCU_BGEU  = 3'b011;
   localparam logic [2:0] BCU_BLT   = 3'b100;
   localparam logic [2:0] BCU_BLTU  = 3'b101;
   localparam logic [2:0] BCU_BNE   = 3'b110;
   localparam logic [2:0] BCU_NONE2 = 3'b111;

   localparam int         CTR_W    = 2;
   localparam logic [1:0] BHT_INIT = 2'b01;

   function automatic logic is_branch(input logic [2:0] op);
      return (op != BCU_NONE) && (op != BCU_NONE2);
   endfunction

endpackage

// File: rtl/bpu_bht.sv
// Direct-mapped table of 2-bit saturating counters: one combinational read
// port for fetch prediction, one synchronous training port.
module bpu_bht
   import bpu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_pred,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   logic [CTR_W-1:0] ctr [DEPTH];

   function automatic logic [CTR_W-1:0] sat_update(input logic [CTR_W-1:0] cur,
                                                    input logic taken);
      if (taken)
         return (cur == {CTR_W{1'b1}}) ? cur : cur + CTR_W'(1);
      else
         return (cur == '0) ? cur : cur - CTR_W'(1);
   endfunction

   // Reads see the pre-update value when the same index trains this cycle.
   assign rd_pred = ctr[rd_idx][CTR_W-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ctr[i] <= BHT_INIT;
      end else if (wr_en) begin
         ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken);
      end
   end

endmodule

// File: rtl/bpu.sv
// Branch resolution + BHT prediction with a one-entry valid/ready output stage.
// Optional performance counters enabled by defining BPU_PERF_EN.
module bpu
   import bpu_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int BHT_DEPTH = 16,
   parameter int CNT_W     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] lookup_pc_i_bpu,
   output logic            pred_taken_o_bpu,
   input  logic            valid_i_bpu,
   output logic            ready_o_bpu,
   input  logic [2:0]      bcuop_i_bpu,
   input  logic [XLEN-1:0] src1_i_bpu,
   input  logic [XLEN-1:0] src2_i_bpu,
   input  logic [XLEN-1:0] pc_i_bpu,
   input  logic [XLEN-1:0] offset_i_bpu,
   input  logic            pred_taken_i_bpu,
   output logic            out_valid_o_bpu,
   input  logic            out_ready_i_bpu,
   output logic            taken_o_bpu,
   output logic [XLEN-1:0] dnpc_o_bpu,
   output logic            redirect_o_bpu,
   output logic [CNT_W-1:0] branch_cnt_o_bpu,
   output logic [CNT_W-1:0] mispred_cnt_o_bpu
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic                   accept;
   logic                   valid_op_p0;
   logic                   taken_p0;
   logic                   redirect_p0;
   logic [XLEN-1:0]        dnpc_p0;
   logic signed [XLEN-1:0] src1_s;
   logic signed [XLEN-1:0] src2_s;
   logic                   eq, lt, ltu;

   logic                   vld_p1;
   logic                   taken_p1;
   logic                   redirect_p1;
   logic [XLEN-1:0]        dnpc_p1;

   logic                   unused_lookup;
   assign unused_lookup = ^{lookup_pc_i_bpu[XLEN-1:IDX_W+2], lookup_pc_i_bpu[1:0]};

   // Stage p0: compare, branch decision and next-PC computation
   assign src1_s = signed'(src1_i_bpu);
   assign src2_s = signed'(src2_i_bpu);
   assign eq     = (src1_i_bpu == src2_i_bpu);
   assign lt     = (src1_s < src2_s);
   assign ltu    = (src1_i_bpu < src2_i_bpu);

   always_comb begin
      taken_p0 = 1'b0;
      case (bcuop_i_bpu)
         BCU_BEQ:  taken_p0 = eq;
         BCU_BNE:  taken_p0 = !eq;
         BCU_BLT:  taken_p0 = lt;
         BCU_BGE:  taken_p0 = !lt;
         BCU_BLTU: taken_p0 = ltu;
         BCU_BGEU: taken_p0 = !ltu;
         default:  taken_p0 = 1'b0;
      endcase
   end

   assign valid_op_p0 = is_branch(bcuop_i_bpu);
   assign dnpc_p0     = taken_p0 ? (pc_i_bpu + (offset_i_bpu << 1)) : (pc_i_bpu + XLEN'(4));
   assign redirect_p0 = taken_p0 ^ pred_taken_i_bpu;

   assign ready_o_bpu = !vld_p1 || out_ready_i_bpu;
   assign accept      = valid_i_bpu && ready_o_bpu;

   bpu_bht #(
      .DEPTH (BHT_DEPTH),
      .IDX_W (IDX_W)
   ) u_bht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (lookup_pc_i_bpu[IDX_W+1:2]),
      .rd_pred  (pred_taken_o_bpu),
      .wr_en    (accept && valid_op_p0),
      .wr_idx   (pc_i_bpu[IDX_W+1:2]),
      .wr_taken (taken_p0)
   );

   // Stage p1: registered result, held while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         taken_p1    <= 1'b0;
         redirect_p1 <= 1'b0;
         dnpc_p1     <= '0;
      end else if (accept) begin
         vld_p1      <= 1'b1;
         taken_p1    <= taken_p0;
         redirect_p1 <= redirect_p0;
         dnpc_p1     <= dnpc_p0;
      end else if (out_ready_i_bpu) begin
         vld_p1      <= 1'b0;
      end
   end

   assign out_valid_o_bpu = vld_p1;
   assign taken_o_bpu     = taken_p1;
   assign redirect_o_bpu  = redirect_p1;
   assign dnpc_o_bpu      = dnpc_p1;

`ifdef BPU_PERF_EN
   logic [CNT_W-1:0] branch_cnt_p1;
   logic [CNT_W-1:0] mispred_cnt_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt_p1  <= '0;
         mispred_cnt_p1 <= '0;
      end else if (accept && valid_op_p0) begin
         branch_cnt_p1 <= branch_cnt_p1 + CNT_W'(1);
         if (redirect_p0) mispred_cnt_p1 <= mispred_cnt_p1 + CNT_W'(1);
      end
   end

   assign branch_cnt_o_bpu  = branch_cnt_p1;
   assign mispred_cnt_o_bpu = mispred_cnt_p1;
`else
   assign branch_cnt_o_bpu  = '0;
   assign mispred_cnt_o_bpu = '0;
`endif

endmodule

// File: tb/tb_bpu.sv
// Self-checking bench for bpu against a behavioural model of the branch rules.
module tb_bpu;

   localparam int XLEN      = 64;
   localparam int BHT_DEPTH = 16;
   localparam int CNT_W     = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] lookup_pc;
   logic            pred_out;
   logic            valid;
   logic            ready;
   logic [2:0]      op;
   logic [XLEN-1:0] src1, src2, pc, offset;
   logic            pred_in;
   logic            out_valid;
   logic            out_ready;
   logic            taken;
   logic [XLEN-1:0] dnpc;
   logic            redirect;
   logic [CNT_W-1:0] branch_cnt, mispred_cnt;

   always #5 clk = ~clk;

   bpu #(.XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .CNT_W(CNT_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .lookup_pc_i_bpu   (lookup_pc),
      .pred_taken_o_bpu  (pred_out),
      .valid_i_bpu       (valid),
      .ready_o_bpu       (ready),
      .bcuop_i_bpu       (op),
      .src1_i_bpu        (src1),
      .src2_i_bpu        (src2),
      .pc_i_bpu          (pc),
      .offset_i_bpu      (offset),
      .pred_taken_i_bpu  (pred_in),
      .out_valid_o_bpu   (out_valid),
      .out_ready_i_bpu   (out_ready),
      .taken_o_bpu       (taken),
      .dnpc_o_bpu        (dnpc),
      .redirect_o_bpu    (redirect),
      .branch_cnt_o_bpu  (branch_cnt),
      .mispred_cnt_o_bpu (mispred_cnt)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   int               m_cnt [BHT_DEPTH];
   bit               m_ov, m_taken, m_redir;
   logic [XLEN-1:0]  m_dnpc;
   logic [CNT_W-1:0] m_bc, m_mc;

   function automatic int idx_of(input logic [XLEN-1:0] a);
      return int'((a >> 2) % BHT_DEPTH);
   endfunction

   function automatic bit ref_taken(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      case (o)
         3'd1: return a == b;
         3'd2: return $signed(a) >= $signed(b);
         3'd3: return a >= b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return a < b;
         3'd6: return a != b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit model_pred(input logic [XLEN-1:0] a);
      return m_cnt[idx_of(a)] >= 2;
   endfunction

   // Advance one clock, updating the model from the inputs present before the edge.
   task automatic tick();
      bit acc, t, vop;
      int i;
      acc = valid && (!m_ov || out_ready);
      vop = (op >= 3'd1) && (op <= 3'd6);
      t   = ref_taken(op, src1, src2);
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < BHT_DEPTH; k++) m_cnt[k] = 1;
         m_ov = 0; m_taken = 0; m_redir = 0; m_dnpc = '0; m_bc = '0; m_mc = '0;
      end else if (acc) begin
         m_ov    = 1;
         m_taken = t;
         m_dnpc  = t ? pc + offset * 2 : pc + 4;
         m_redir = t ^ pred_in;
         if (vop) begin
            i = idx_of(pc);
            if (t && m_cnt[i] < 3) m_cnt[i]++;
            else if (!t && m_cnt[i] > 0) m_cnt[i]--;
`ifdef BPU_PERF_EN
            m_bc++;
            if (t ^ pred_in) m_mc++;
`endif
         end
      end else if (out_ready) begin
         m_ov = 0;
      end
      #1;
   endtask

   task automatic set_req(input bit v, input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] p, input logic [XLEN-1:0] off, input bit pr);
      valid = v; op = o; src1 = a; src2 = b; pc = p; offset = off; pred_in = pr;
   endtask

   task automatic test_reset();
      rst = 1; out_ready = 1; lookup_pc = '0;
      set_req(0, 3'd0, '0, '0, '0, '0, 0);
      tick(); tick();
      rst = 0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      total++; if (taken !== 1'b0) begin bad++; $display("FAIL reset_taken: got %0b want 0", taken); end
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect: got %0b want 0", redirect); end
      total++; if (dnpc !== '0) begin bad++; $display("FAIL reset_dnpc: got %0h want 0", dnpc); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", ready); end
      total++; if (branch_cnt !== '0 || mispred_cnt !== '0) begin bad++; $display("FAIL reset_perf: got %0d/%0d want 0/0", branch_cnt, mispred_cnt); end
      for (int i = 0; i < BHT_DEPTH; i++) begin
         lookup_pc = 64'h8000_0000 + XLEN'(i * 4);
         #1;
         total++; if (pred_out !== 1'b0) begin bad++; $display("FAIL reset_pred[%0d]: got %0b want 0", i, pred_out); end
      end
   endtask

   task automatic test_directed();
      out_ready = 1;
      lookup_pc = 64'h8000_0000;
      #1;
      total++; if (pred_out !== 1'b0) begin bad++; $display("FAIL dir_lookup: got %0b want 0", pred_out); end
      set_req(1, 3'd1, 64'd5, 64'd5, 64'h8000_0000, 64'h8, 0);
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dir_beq_valid: got %0b want 1", out_valid); end
      total++; if (taken !== 1'b1) begin bad++; $display("FAIL dir_beq_taken: got %0b want 1", taken); end
      total++; if (dnpc !== 64'h8000_0010) begin bad++; $display("FAIL dir_beq_dnpc: got %0h want 80000010", dnpc); end
      total++; if (redirect !== 1'b1) begin bad++; $display("FAIL dir_beq_redirect: got %0b want 1", redirect); end
      set_req(1, 3'd4, '1, 64'd1, 64'h8000_0000, 64'h8, 1);
      tick();
      total++; if (taken !== 1'b1) begin bad++; $display("FAIL dir_blt_taken: got %0b want 1", taken); end
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL dir_blt_redirect: got %0b want 0", redirect); end
      set_req(1, 3'd5, '1, 64'd1, 64'h8000_0000, 64'h8, 1);
      tick();
      total++; if (taken !== 1'b0) begin bad++; $display("FAIL dir_bltu_taken: got %0b want 0", taken); end
      total++; if (dnpc !== 64'h8000_0004) begin bad++; $display("FAIL dir_bltu_dnpc: got %0h want 80000004", dnpc); end
      set_req(0, 3'd0, '0, '0, '0, '0, 0);
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir_drain: got %0b want 0", out_valid); end
   endtask

   task automatic test_saturate();
      bit exp_t [3] = '{1'b0, 1'b1, 1'b1};
      bit exp_n [2] = '{1'b1, 1'b0};
      out_ready = 1;
      lookup_pc = 64'h8000_0044;
      for (int k = 0; k < 3; k++) begin
         set_req(1, 3'd1, 64'd7, 64'd7, 64'h8000_0044, 64'h10, 0);
         #1;
         total++; if (pred_out !== exp_t[k]) begin bad++; $display("FAIL sat_taken_pred[%0d]: got %0b want %0b", k, pred_out, exp_t[k]); end
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         set_req(1, 3'd6, 64'd7, 64'd7, 64'h8000_0044, 64'h10, 1);
         tick();
         total++; if (pred_out !== exp_n[k]) begin bad++; $display("FAIL sat_nt_pred[%0d]: got %0b want %0b", k, pred_out, exp_n[k]); end
      end
      set_req(0, 3'd0, '0, '0, '0, '0, 0);
      tick();
   endtask

   task automatic test_backpressure();
      bit s_t, s_r;
      logic [XLEN-1:0] s_d;
      out_ready = 0;
      set_req(1, 3'd1, 64'd5, 64'd5, 64'h8000_0100, 64'h20, 0);
      tick();
      s_t = taken; s_r = redirect; s_d = dnpc;
      total++; if (out_valid !== 1'b1 || dnpc !== m_dnpc) begin bad++; $display("FAIL bp_first: got v=%0b d=%0h want v=1 d=%0h", out_valid, dnpc, m_dnpc); end
      set_req(1, 3'd6, 64'd5, 64'd5, 64'h8000_0200, 64'h20, 1);
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %0b want 0", k, ready); end
         tick();
         total++; if (out_valid !== 1'b1 || taken !== s_t || redirect !== s_r || dnpc !== s_d) begin
            bad++; $display("FAIL bp_hold[%0d]: got v=%0b t=%0b r=%0b d=%0h want v=1 t=%0b r=%0b d=%0h", k, out_valid, taken, redirect, dnpc, s_t, s_r, s_d);
         end
      end
      out_ready = 1;
      #1;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %0b want 1", ready); end
      tick();
      total++; if (out_valid !== 1'b1 || dnpc !== m_dnpc || taken !== m_taken || redirect !== m_redir) begin
         bad++; $display("FAIL bp_next: got v=%0b t=%0b r=%0b d=%0h want v=1 t=%0b r=%0b d=%0h", out_valid, taken, redirect, dnpc, m_taken, m_redir, m_dnpc);
      end
      set_req(0, 3'd0, '0, '0, '0, '0, 0);
      tick();
   endtask

   task automatic test_random();
      logic [XLEN-1:0] a, b, p, off;
      for (int n = 0; n < 400; n++) begin
         a   = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 3)) : {$urandom, $urandom};
         b   = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
         p   = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'h8000_0000 + XLEN'($urandom_range(0, 63) * 4);
         off = XLEN'($signed($urandom_range(0, 4095) << 20) >>> 20);
         set_req($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b, p, off, 1'($urandom_range(0, 1)));
         out_ready = ($urandom_range(0, 3) != 0);
         lookup_pc = ($urandom_range(0, 1) == 0) ? p : 64'h8000_0000 + XLEN'($urandom_range(0, 63) * 4);
         #1;
         total++; if (ready !== (!m_ov || out_ready)) begin bad++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", n, ready, (!m_ov || out_ready)); end
         total++; if (pred_out !== model_pred(lookup_pc)) begin bad++; $display("FAIL rnd_pred[%0d]: got %0b want %0b", n, pred_out, model_pred(lookup_pc)); end
         tick();
         total++; if (out_valid !== m_ov || taken !== m_taken || redirect !== m_redir || dnpc !== m_dnpc) begin
            bad++; $display("FAIL rnd_out[%0d]: got v=%0b t=%0b r=%0b d=%0h want v=%0b t=%0b r=%0b d=%0h", n, out_valid, taken, redirect, dnpc, m_ov, m_taken, m_redir, m_dnpc);
         end
         total++; if (branch_cnt !== m_bc || mispred_cnt !== m_mc) begin bad++; $display("FAIL rnd_perf[%0d]: got %0d/%0d want %0d/%0d", n, branch_cnt, mispred_cnt, m_bc, m_mc); end
      end
      set_req(0, 3'd0, '0, '0, '0, '0, 0);
      out_ready = 1;
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 0;
      lookup_pc = 64'h8000_0008;
      set_req(1, 3'd1, 64'd3, 64'd3, 64'h8000_0008, 64'h4, 0);
      tick();
      tick();
      rst = 1;
      tick();
      rst = 0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
      total++; if (pred_out !== 1'b0) begin bad++; $display("FAIL rstmid_pred: got %0b want 0", pred_out); end
      out_ready = 1;
      tick();
      total++; if (pred_out !== 1'b1) begin bad++; $display("FAIL rstmid_ctr01: got %0b want 1", pred_out); end
      set_req(0, 3'd0, '0, '0, '0, '0, 0);
      tick();
   endtask

   task automatic test_perf();
      logic [CNT_W-1:0] eb, em;
      rst = 1; tick(); rst = 0;
      out_ready = 1;
      set_req(1, 3'd1, 64'd1, 64'd1, 64'h8000_0300, 64'h4, 1); tick();
      set_req(1, 3'd6, 64'd1, 64'd2, 64'h8000_0304, 64'h4, 1); tick();
      set_req(1, 3'd4, 64'd2, 64'd1, 64'h8000_0308, 64'h4, 0); tick();
      set_req(1, 3'd3, 64'd1, 64'd2, 64'h8000_030c, 64'h4, 1); tick();
      set_req(1, 3'd0, 64'd1, 64'd1, 64'h8000_0310, 64'h4, 0); tick();
      set_req(0, 3'd0, '0, '0, '0, '0, 0); tick();
`ifdef BPU_PERF_EN
      eb = 4; em = 1;
`else
      eb = 0; em = 0;
`endif
      total++; if (branch_cnt !== eb) begin bad++; $display("FAIL perf_branch: got %0d want %0d", branch_cnt, eb); end
      total++; if (mispred_cnt !== em) begin bad++; $display("FAIL perf_mispred: got %0d want %0d", mispred_cnt, em); end
   endtask

   initial begin
      for (int k = 0; k < BHT_DEPTH; k++) m_cnt[k] = 1;
      m_ov = 0; m_taken = 0; m_redir = 0; m_dnpc = '0; m_bc = '0; m_mc = '0;
      test_reset();
      test_directed();
      test_saturate();
      test_backpressure();
      test_random();
      test_reset_mid();
      test_perf();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bpu.md
# bpu

Branch resolution and prediction unit for the NPC core's execute stage. Evaluates conditional branches on raw operands for any XLEN and keeps a direct-mapped table of 2-bit saturating counters indexed by PC. The table serves taken/not-taken predictions to fetch and is trained by each resolved branch. Results leave through a one-entry registered output stage with valid/ready handshake and a redirect flag when the prediction was wrong.

## Interface
- XLEN, 64, datapath width of operands, PC and offset
- BHT_DEPTH, 16, number of counters; power of two, >= 2
- CNT_W, 32, width of performance counters
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- lookup_pc_i_bpu  in  XLEN  fetch PC to predict
- pred_taken_o_bpu  out  1  combinational prediction for lookup_pc_i_bpu
- valid_i_bpu  in  1  resolve request valid
- ready_o_bpu  out  1  unit can accept a resolve request
- bcuop_i_bpu  in  3  001 beq, 010 bge, 011 bgeu, 100 blt, 101 bltu, 110 bne; 000/111 no branch
- src1_i_bpu, src2_i_bpu  in  XLEN  compare operands
- pc_i_bpu  in  XLEN  PC of the branch
- offset_i_bpu  in  XLEN  sign-extended B-immediate without bit 0
- pred_taken_i_bpu  in  1  prediction fetch used for this branch
- out_valid_o_bpu  out  1  result valid
- out_ready_i_bpu  in  1  consumer accepts result
- taken_o_bpu  out  1  branch resolved taken
- dnpc_o_bpu  out  XLEN  correct next PC
- redirect_o_bpu  out  1  taken_o_bpu differs from pred_taken_i_bpu
- branch_cnt_o_bpu, mispred_cnt_o_bpu  out  CNT_W  performance counters

## Operation
- Index: pc[$clog2(BHT_DEPTH)+1:2] for both lookup and train.
- pred_taken_o_bpu = MSB of indexed counter (00,01 not taken; 10,11 taken).
- Compare: eq = src1==src2; lt signed; ltu unsigned; all XLEN wide.
- taken: beq eq; bne !eq; blt lt; bge !lt; bltu ltu; bgeu !ltu; 000/111 -> 0.
- dnpc = taken ? pc + (offset << 1) : pc + 4, truncated modulo 2^XLEN.
- redirect = taken XOR pred_taken_i_bpu (also for 000/111: redirect = pred_taken_i_bpu).
- Accept = valid_i_bpu & ready_o_bpu. On accept: output register loads taken, dnpc, redirect; out_valid set.
- Training on accept with valid op only: counter +1 saturating at 11 if taken, -1 saturating at 00 if not. 000/111 never train.
- ready_o_bpu = !out_valid_o_bpu | out_ready_i_bpu (pass-through, no bubble under continuous flow).
- out_valid clears when out_ready_i_bpu high and no new accept.

## Timing
- Resolve latency 1 cycle: accept in cycle N, result visible cycle N+1.
- Output holds stable while out_valid & !out_ready.
- Counter write in cycle of accept takes effect next edge; same-cycle lookup of same index sees old value.
- Reset: all counters 01, out_valid 0, taken 0, redirect 0, dnpc 0, perf counters 0. Reset mid-transfer drops the pending result; rst wins over accept in same cycle.

## Configuration
- BPU_PERF_EN defined: on each accept with valid op, branch_cnt +1; if redirect also mispred_cnt +1; both wrap at 2^CNT_W.
- Undefined: no counter registers; both outputs tied to 0.

## Structure
- Shared package/define file: bcuop encodings (3-bit constants), BHT counter reset value 2'b01, counter width 2.
- One sub-module natural: bpu_bht (counter array, combinational read port, saturating update port, reset init).

## Test plan
- Reset, then lookup pc 0x80000000 -> pred 0; beq src1=src2=5, pc 0x80000000, offset 0x8, pred 0 -> next cycle taken 1, dnpc 0x80000010, redirect 1.
- blt src1=-1 src2=1 -> taken 1; bltu same operands -> taken 0, dnpc pc+4.
- Three taken branches at one PC -> pred goes 0,1,1 and counter saturates at 11; two not-taken -> pred 0 (counter 01).
- out_ready held 0 for 3 cycles -> ready_o 0, outputs stable; release -> new request accepted same cycle as drain.
- rst asserted while out_valid 1 and valid_i 1 -> next cycle out_valid 0, counters 01.
- BPU_PERF_EN: 4 branches, 1 mispredicted, 1 op 000 -> branch_cnt 4, mispred_cnt 1; without macro both 0.
